rom_load_arbiter: RTL and testbench

// Shares the SPRINT1 program/graphics ROM between the ioctl download path (dn_addr/dn_data/dn_wr)
// and the core's read port. Holds the core in reset while a download runs and for a fixed

---
 rtl/rom_load_arbiter_if.sv | 47 ++++
 rtl/rom_load_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rom_load_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_load_arbiter_if
// Bundles the loader, core read port and ROM port signals of the SPRINT1 ROM
// arbiter into one interface.
//   slave  : arbiter side (takes loader/CPU requests, drives the ROM)
//   master : environment side (loader, core, ROM storage)
// Signals:
//   dn_download, dn_addr, dn_data, dn_wr : ioctl download path
//   cpu_req, cpu_addr, cpu_data, cpu_ack : core read port
//   mem_addr, mem_wdata, mem_we, mem_rdata : ROM storage port (sync read)
//   core_reset_n                         : active-low core reset
//   dl_count, dl_stray                   : download statistics
// ---------------------------------------------------------------------------
interface rom_load_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              dn_download;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              dn_wr;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              core_reset_n;
  logic [ADDR_W:0]   dl_count;
  logic              dl_stray;

  modport slave (
    input  dn_download, dn_addr, dn_data, dn_wr,
    input  cpu_req, cpu_addr, mem_rdata,
    output cpu_data, cpu_ack, mem_addr, mem_wdata, mem_we,
    output core_reset_n, dl_count, dl_stray
  );

  modport master (
    output dn_download, dn_addr, dn_data, dn_wr,
    output cpu_req, cpu_addr, mem_rdata,
    input  cpu_data, cpu_ack, mem_addr, mem_wdata, mem_we,
    input  core_reset_n, dl_count, dl_stray
  );
endinterface

// File: rtl/rom_load_arbiter.sv
// ---------------------------------------------------------------------------
// rom_load_arbiter
// Shares the SPRINT1 program/graphics ROM between the ioctl download path and
// the core's read port. The core is held in reset while a download runs and
// for RESET_HOLD cycles after it ends (or after system reset).
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : rom_load_arbiter_if.slave (loader, CPU read port, ROM port,
//            core_reset_n, dl_count, dl_stray)
// All outputs are registered.
// ---------------------------------------------------------------------------
module rom_load_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int ROM_BYTES  = 16384,
  parameter int RESET_HOLD = 16
) (
  input  logic           clk,
  input  logic           reset,
  rom_load_arbiter_if.slave bus
);

  localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W + 1)'(ROM_BYTES);
  localparam logic [ADDR_W:0]   DL_MAX    = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_DRAIN, S_RUN} state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ACK} rd_t;

  state_t            state, state_nxt;
  rd_t               rd, rd_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic              core_reset_n_q, core_reset_n_nxt;
  logic              cpu_ack_q, cpu_ack_nxt;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [ADDR_W:0]   dl_count_q, dl_count_nxt;
  logic              dl_stray_q, dl_stray_nxt;

  logic              wr_ok;

  // Writes beyond the writable ROM window are silently dropped.
  assign wr_ok = bus.dn_wr && ({1'b0, bus.dn_addr} < ROM_LIMIT);

  // State, hold counter and read-phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HOLD;
      rd       <= RD_IDLE;
      hold_cnt <= HOLD_INIT;
    end else begin
      state    <= state_nxt;
      rd       <= rd_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Output registers; an async reset also discards a write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_reset_n_q <= 1'b0;
      cpu_ack_q      <= 1'b0;
      cpu_data_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      dl_count_q     <= '0;
      dl_stray_q     <= 1'b0;
    end else begin
      core_reset_n_q <= core_reset_n_nxt;
      cpu_ack_q      <= cpu_ack_nxt;
      cpu_data_q     <= cpu_data_nxt;
      mem_we_q       <= mem_we_nxt;
      mem_addr_q     <= mem_addr_nxt;
      mem_wdata_q    <= mem_wdata_nxt;
      dl_count_q     <= dl_count_nxt;
      dl_stray_q     <= dl_stray_nxt;
    end
  end

  // Next-state and next-output logic. A captured download write goes
  // straight into the ROM port registers, so capture and issue of
  // consecutive strobes overlap and back-to-back writes are never lost.
  always_comb begin
    state_nxt        = state;
    rd_nxt           = rd;
    hold_nxt         = hold_cnt;
    core_reset_n_nxt = 1'b0;
    cpu_ack_nxt      = 1'b0;
    cpu_data_nxt     = cpu_data_q;
    mem_we_nxt       = 1'b0;
    mem_addr_nxt     = mem_addr_q;
    mem_wdata_nxt    = mem_wdata_q;
    dl_count_nxt     = dl_count_q;
    // In LOAD a strobe with dn_download low is the final write of the
    // download, not a stray one.
    dl_stray_nxt     = dl_stray_q |
                       (bus.dn_wr & ~bus.dn_download & (state != S_LOAD));

    case (state)
      S_HOLD: begin
        if (bus.dn_download) begin
          state_nxt    = S_LOAD;
          dl_count_nxt = '0;
        end else if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt        = S_RUN;
          hold_nxt         = '0;
          core_reset_n_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end

      S_LOAD: begin
        if (wr_ok) begin
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = bus.dn_addr;
          mem_wdata_nxt = bus.dn_data;
          if (dl_count_q != DL_MAX) begin
            dl_count_nxt = dl_count_q + (ADDR_W + 1)'(1);
          end
        end
        if (!bus.dn_download) begin
          state_nxt = S_DRAIN;
        end
      end

      // Any write captured on the last LOAD cycle is on the ROM port now.
      S_DRAIN: begin
        state_nxt = S_HOLD;
        hold_nxt  = HOLD_INIT;
      end

      S_RUN: begin
        if (bus.dn_download) begin
          // Abandon any outstanding read without acknowledging it.
          state_nxt    = S_LOAD;
          rd_nxt       = RD_IDLE;
          dl_count_nxt = '0;
        end else begin
          core_reset_n_nxt = 1'b1;
          case (rd)
            RD_IDLE: begin
              if (bus.cpu_req) begin
                mem_addr_nxt = bus.cpu_addr;
                rd_nxt       = RD_ADDR;
              end
            end
            RD_ADDR: rd_nxt = RD_DATA;
            RD_DATA: begin
              cpu_data_nxt = bus.mem_rdata;
              cpu_ack_nxt  = 1'b1;
              rd_nxt       = RD_ACK;
            end
            default: rd_nxt = RD_IDLE;
          endcase
        end
      end

      default: begin
        state_nxt = S_HOLD;
        hold_nxt  = HOLD_INIT;
      end
    endcase
  end

  assign bus.core_reset_n = core_reset_n_q;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.cpu_data     = cpu_data_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.dl_count     = dl_count_q;
  assign bus.dl_stray     = dl_stray_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_load_arbiter
// Self-checking bench for rom_load_arbiter with a behavioural sync-read ROM.
// Expected writes and read data are queued when stimulus is driven and
// popped when the DUT pulses mem_we or cpu_ack.
// ---------------------------------------------------------------------------
module tb_rom_load_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    rd_q[$];
  logic [DW-1:0]    rom [0:16383];

  rom_load_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  rom_load_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_BYTES(16384), .RESET_HOLD(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Behavioural ROM storage: sync write, sync read one cycle after address
  always @(posedge clk) begin
    if (bus.mem_we) rom[bus.mem_addr[13:0]] <= bus.mem_wdata;
    bus.mem_rdata <= rom[bus.mem_addr[13:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits up to max_cycles for cpu_ack, reporting whether it was seen
  task automatic wait_ack(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.cpu_ack === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.core_reset_n !== 1'b0) $display("[TB] FAIL rst_core_n: got %b want 0", bus.core_reset_n); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL rst_mem_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL rst_cpu_ack: got %b want 0", bus.cpu_ack); else passed++;
    checks++; if (bus.cpu_data !== 8'h00) $display("[TB] FAIL rst_cpu_data: got %h want 00", bus.cpu_data); else passed++;
    checks++; if (bus.mem_addr !== 17'h0) $display("[TB] FAIL rst_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.mem_wdata !== 8'h00) $display("[TB] FAIL rst_mem_wdata: got %h want 00", bus.mem_wdata); else passed++;
    checks++; if (bus.dl_count !== 18'h0) $display("[TB] FAIL rst_dl_count: got %0d want 0", bus.dl_count); else passed++;
    checks++; if (bus.dl_stray !== 1'b0) $display("[TB] FAIL rst_dl_stray: got %b want 0", bus.dl_stray); else passed++;
    // Release; hold cpu_req to show it is ignored until RUN
    reset = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 17'h5;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (bus.core_reset_n !== (i == 16)) $display("[TB] FAIL hold_core_n cycle %0d: got %b want %b", i, bus.core_reset_n, (i == 16)); else passed++;
      checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL hold_no_ack cycle %0d: got %b want 0", i, bus.cpu_ack); else passed++;
      checks++; if (bus.mem_addr !== 17'h0) $display("[TB] FAIL hold_mem_addr cycle %0d: got %h want 0", i, bus.mem_addr); else passed++;
      if (i == 16) bus.cpu_req = 1'b0;
    end
  endtask

  task automatic test_download;
    logic [AW+DW-1:0] exp;
    bus.dn_download = 1'b1;
    tick();
    checks++; if (bus.core_reset_n !== 1'b0) $display("[TB] FAIL load_core_n: got %b want 0", bus.core_reset_n); else passed++;
    checks++; if (bus.dl_count !== 18'd0) $display("[TB] FAIL load_entry_count: got %0d want 0", bus.dl_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus.dn_wr   = 1'b1;
      bus.dn_addr = AW'(i);
      bus.dn_data = DW'(8'hA0 + i);
      wr_q.push_back({bus.dn_addr, bus.dn_data});
      tick();
      checks++;
      if (bus.mem_we !== 1'b1 || wr_q.size() == 0) begin
        $display("[TB] FAIL b2b_we %0d: got mem_we=%b want 1", i, bus.mem_we);
      end else begin
        exp = wr_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp)
          $display("[TB] FAIL b2b_write %0d: got %h/%h want %h/%h", i, bus.mem_addr, bus.mem_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
        else passed++;
      end
      checks++; if (bus.dl_count !== 18'(i + 1)) $display("[TB] FAIL b2b_count %0d: got %0d want %0d", i, bus.dl_count, i + 1); else passed++;
      checks++; if (bus.core_reset_n !== 1'b0) $display("[TB] FAIL b2b_core_n %0d: got %b want 0", i, bus.core_reset_n); else passed++;
    end
    bus.dn_wr = 1'b0;
    tick();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL b2b_we_end: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.dl_count !== 18'd4) $display("[TB] FAIL b2b_count_end: got %0d want 4", bus.dl_count); else passed++;
  endtask

  task automatic test_drain;
    logic [AW+DW-1:0] exp;
    bus.dn_wr       = 1'b1;
    bus.dn_download = 1'b0;
    bus.dn_addr     = 17'h4;
    bus.dn_data     = 8'hA4;
    wr_q.push_back({bus.dn_addr, bus.dn_data});
    tick();
    bus.dn_wr = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b1 || wr_q.size() == 0) begin
      $display("[TB] FAIL drain_we: got mem_we=%b want 1", bus.mem_we);
    end else begin
      exp = wr_q.pop_front();
      if ({bus.mem_addr, bus.mem_wdata} !== exp)
        $display("[TB] FAIL drain_write: got %h/%h want %h/%h", bus.mem_addr, bus.mem_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
      else passed++;
    end
    checks++; if (bus.dl_count !== 18'd5) $display("[TB] FAIL drain_count: got %0d want 5", bus.dl_count); else passed++;
    checks++; if (bus.dl_stray !== 1'b0) $display("[TB] FAIL drain_no_stray: got %b want 0", bus.dl_stray); else passed++;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++; if (bus.core_reset_n !== (i == 17)) $display("[TB] FAIL drain_hold_core_n cycle %0d: got %b want %b", i, bus.core_reset_n, (i == 17)); else passed++;
      checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL drain_hold_we cycle %0d: got %b want 0", i, bus.mem_we); else passed++;
    end
    checks++; if (bus.dl_count !== 18'd5) $display("[TB] FAIL run_count_held: got %0d want 5", bus.dl_count); else passed++;
  endtask

  task automatic test_read;
    bit seen;
    logic [DW-1:0] exp;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 17'h2;
    rd_q.push_back(8'hA2);
    tick();
    checks++; if (bus.mem_addr !== 17'h2) $display("[TB] FAIL rd_addr_N: got %h want 2", bus.mem_addr); else passed++;
    checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL rd_ack_N: got %b want 0", bus.cpu_ack); else passed++;
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL rd_ack_N1: got %b want 0", bus.cpu_ack); else passed++;
    tick();
    checks++;
    if (bus.cpu_ack !== 1'b1 || rd_q.size() == 0) begin
      $display("[TB] FAIL rd_ack_N2: got cpu_ack=%b want 1", bus.cpu_ack);
    end else begin
      exp = rd_q.pop_front();
      if (bus.cpu_data !== exp) $display("[TB] FAIL rd_data_N2: got %h want %h", bus.cpu_data, exp);
      else passed++;
    end
    // Keep cpu_req held for a second read at a new address
    bus.cpu_addr = 17'h3;
    rd_q.push_back(8'hA3);
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL rd_ack_single_pulse: got %b want 0", bus.cpu_ack); else passed++;
    wait_ack(8, seen);
    bus.cpu_req = 1'b0;
    checks++;
    if (!seen || rd_q.size() == 0) begin
      $display("[TB] FAIL rd2_ack_timeout: got no cpu_ack want cpu_ack within 8 cycles");
    end else begin
      exp = rd_q.pop_front();
      if (bus.cpu_data !== exp) $display("[TB] FAIL rd2_data: got %h want %h", bus.cpu_data, exp);
      else passed++;
    end
    tick(); tick();
  endtask

  task automatic test_drop_stray;
    logic [AW+DW-1:0] exp;
    bit seen;
    logic [DW-1:0] rexp;
    int cyc;
    bus.dn_download = 1'b1;
    tick();
    checks++; if (bus.dl_count !== 18'd0) $display("[TB] FAIL reload_count_clear: got %0d want 0", bus.dl_count); else passed++;
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 17'h4000;
    bus.dn_data = 8'h55;
    tick();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL drop_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.dl_count !== 18'd0) $display("[TB] FAIL drop_count: got %0d want 0", bus.dl_count); else passed++;
    bus.dn_addr = 17'h3FFF;
    bus.dn_data = 8'h77;
    wr_q.push_back({bus.dn_addr, bus.dn_data});
    tick();
    bus.dn_wr = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b1 || wr_q.size() == 0) begin
      $display("[TB] FAIL edge_we: got mem_we=%b want 1", bus.mem_we);
    end else begin
      exp = wr_q.pop_front();
      if ({bus.mem_addr, bus.mem_wdata} !== exp)
        $display("[TB] FAIL edge_write: got %h/%h want %h/%h", bus.mem_addr, bus.mem_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
      else passed++;
    end
    checks++; if (bus.dl_count !== 18'd1) $display("[TB] FAIL edge_count: got %0d want 1", bus.dl_count); else passed++;
    bus.dn_download = 1'b0;
    tick();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL drain_empty_we: got %b want 0", bus.mem_we); else passed++;
    cyc = 0;
    while (bus.core_reset_n !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 17) $display("[TB] FAIL drain_empty_hold: got %0d cycles want 17", cyc); else passed++;
    // Stray strobe in RUN
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 17'h0;
    bus.dn_data = 8'hEE;
    tick();
    bus.dn_wr = 1'b0;
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL stray_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.dl_stray !== 1'b1) $display("[TB] FAIL stray_flag: got %b want 1", bus.dl_stray); else passed++;
    tick();
    checks++; if (bus.dl_stray !== 1'b1) $display("[TB] FAIL stray_sticky: got %b want 1", bus.dl_stray); else passed++;
    checks++; if (bus.dl_count !== 18'd1) $display("[TB] FAIL stray_count: got %0d want 1", bus.dl_count); else passed++;
    // Read back the last writable byte and address 0 (untouched by stray/drop)
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 17'h3FFF;
    rd_q.push_back(8'h77);
    wait_ack(8, seen);
    bus.cpu_req = 1'b0;
    checks++;
    if (!seen || rd_q.size() == 0) $display("[TB] FAIL rd_edge_timeout: got no cpu_ack want cpu_ack within 8 cycles");
    else begin
      rexp = rd_q.pop_front();
      if (bus.cpu_data !== rexp) $display("[TB] FAIL rd_edge_data: got %h want %h", bus.cpu_data, rexp);
      else passed++;
    end
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 17'h0;
    rd_q.push_back(8'hA0);
    wait_ack(8, seen);
    bus.cpu_req = 1'b0;
    checks++;
    if (!seen || rd_q.size() == 0) $display("[TB] FAIL rd_zero_timeout: got no cpu_ack want cpu_ack within 8 cycles");
    else begin
      rexp = rd_q.pop_front();
      if (bus.cpu_data !== rexp) $display("[TB] FAIL rd_zero_data: got %h want %h", bus.cpu_data, rexp);
      else passed++;
    end
    tick(); tick();
  endtask

  task automatic test_abort_and_reset;
    int cyc;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 17'h1;
    tick();
    checks++; if (bus.mem_addr !== 17'h1) $display("[TB] FAIL abort_rd_addr: got %h want 1", bus.mem_addr); else passed++;
    bus.dn_download = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    checks++; if (bus.core_reset_n !== 1'b0) $display("[TB] FAIL abort_core_n: got %b want 0", bus.core_reset_n); else passed++;
    checks++; if (bus.dl_count !== 18'd0) $display("[TB] FAIL abort_count_clear: got %0d want 0", bus.dl_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.cpu_ack !== 1'b0) $display("[TB] FAIL abort_no_ack %0d: got %b want 0", i, bus.cpu_ack); else passed++;
      tick();
    end
    // Write in flight when reset hits
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 17'h7;
    bus.dn_data = 8'h99;
    tick();
    bus.dn_wr = 1'b0;
    checks++; if (bus.mem_we !== 1'b1) $display("[TB] FAIL pend_we: got %b want 1", bus.mem_we); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL async_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.mem_addr !== 17'h0) $display("[TB] FAIL async_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.mem_wdata !== 8'h00) $display("[TB] FAIL async_mem_wdata: got %h want 00", bus.mem_wdata); else passed++;
    checks++; if (bus.dl_count !== 18'd0) $display("[TB] FAIL async_count: got %0d want 0", bus.dl_count); else passed++;
    checks++; if (bus.dl_stray !== 1'b0) $display("[TB] FAIL async_stray: got %b want 0", bus.dl_stray); else passed++;
    checks++; if (bus.cpu_data !== 8'h00) $display("[TB] FAIL async_cpu_data: got %h want 00", bus.cpu_data); else passed++;
    bus.dn_download = 1'b0;
    tick();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL async_we_held: got %b want 0", bus.mem_we); else passed++;
    reset = 1'b0;
    cyc = 0;
    while (bus.core_reset_n !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 16) $display("[TB] FAIL rerun_hold: got %0d cycles want 16", cyc); else passed++;
  endtask

  initial begin
    bus.dn_download = 1'b0;
    bus.dn_addr     = '0;
    bus.dn_data     = '0;
    bus.dn_wr       = 1'b0;
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    #2;
    test_reset();
    test_download();
    test_drain();
    test_read();
    test_drop_stray();
    test_abort_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
